// File: rtl/alarm_bank.sv
// alarm_bank: multi-channel alarm controller between the time-of-day
// counters and the buzzer driver; every channel has its own FSM.
//
// Ports:
//   Pulse, Reset        clock, synchronous active-high reset
//   tmin/thrs/tdays     current time of day, valid with min_tick
//   min_tick            one-cycle strobe on each new minute
//   wr_en/wr_idx/wr_*   program one channel (time, day code, armed)
//   ack, snooze         user controls, applied to all channels
//   buzz                buzzer drive (OR of ringing channels)
//   ringing, snoozing   per-channel RING / SNOOZE state
//
// Build option: ALARM_BEEP_EN gates buzz with a toggling beep phase.

module alarm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int RING_MIN   = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3,
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  Pulse,
    input  logic                  Reset,
    input  logic [6:0]            tmin,
    input  logic [6:0]            thrs,
    input  logic [6:0]            tdays,
    input  logic                  min_tick,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [6:0]            wr_min,
    input  logic [6:0]            wr_hrs,
    input  logic [6:0]            wr_days,
    input  logic                  wr_arm,
    input  logic                  ack,
    input  logic                  snooze,
    output logic                  buzz,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [NUM_ALARMS-1:0] snoozing
);

    localparam int RW = $clog2(RING_MIN + 1);
    localparam int SW = $clog2(SNOOZE_MIN + 1);
    localparam int UW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    // Codes 0..5 skip that day and the next (3-bit wrap); 6 skips the
    // weekend pair 0/6; 7 and above ring every day.
    function automatic logic day_ok(input logic [2:0] code,
                                    input logic [6:0] d);
        logic [2:0] c1;
        c1 = code + 3'd1;
        case (code)
            3'd7:    day_ok = 1'b1;
            3'd6:    day_ok = (d != 7'd0) && (d != 7'd6);
            default: day_ok = (d != {4'b0, code}) && (d != {4'b0, c1});
        endcase
    endfunction

    logic [NUM_ALARMS-1:0] ring_n;

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        logic [6:0]    amin;
        logic [6:0]    ahrs;
        logic [2:0]    aday;
        logic          armed;
        state_t        st;
        state_t        st_n;
        logic [RW-1:0] rc;
        logic [RW-1:0] rc_n;
        logic [SW-1:0] sc;
        logic [SW-1:0] sc_n;
        logic [UW-1:0] su;
        logic [UW-1:0] su_n;
        logic          sel;
        logic          hit;

        assign sel = wr_en && (wr_idx == IW'(g));
        assign hit = armed && (tmin == amin) && (thrs == ahrs)
                     && day_ok(aday, tdays);

        always_ff @(posedge Pulse) begin
            if (Reset) begin
                amin  <= '0;
                ahrs  <= '0;
                aday  <= '0;
                armed <= 1'b0;
                st    <= IDLE;
                rc    <= '0;
                sc    <= '0;
                su    <= '0;
            end else begin
                st <= st_n;
                rc <= rc_n;
                sc <= sc_n;
                su <= su_n;
                if (sel) begin
                    amin  <= wr_min;
                    ahrs  <= wr_hrs;
                    aday  <= (wr_days >= 7'd7) ? 3'd7 : wr_days[2:0];
                    armed <= wr_arm;
                end
            end
        end

        always_comb begin
            st_n = st;
            rc_n = rc;
            sc_n = sc;
            su_n = su;
            if (sel) begin
                // A write always lands the channel in IDLE, which also
                // silences it when the alarm gets disarmed.
                st_n = IDLE;
                rc_n = '0;
                sc_n = '0;
                su_n = '0;
            end else if (ack && (st != IDLE)) begin
                st_n = IDLE;
            end else if (snooze && (st == RING)) begin
                if (su < UW'(MAX_SNOOZE)) begin
                    st_n = SNOOZE;
                    sc_n = SW'(SNOOZE_MIN);
                    su_n = su + UW'(1);
                end else begin
                    st_n = IDLE;
                end
            end else if (min_tick) begin
                case (st)
                    IDLE: begin
                        if (hit) begin
                            st_n = RING;
                            rc_n = RW'(RING_MIN);
                            su_n = '0;
                        end
                    end
                    RING: begin
                        if (rc <= RW'(1)) begin
                            st_n = IDLE;
                            rc_n = '0;
                        end else begin
                            rc_n = rc - RW'(1);
                        end
                    end
                    SNOOZE: begin
                        if (sc <= SW'(1)) begin
                            st_n = RING;
                            sc_n = '0;
                            rc_n = RW'(RING_MIN);
                        end else begin
                            sc_n = sc - SW'(1);
                        end
                    end
                    default: st_n = IDLE;
                endcase
            end
        end

        assign ring_n[g]   = (st_n == RING);
        assign ringing[g]  = (st == RING);
        assign snoozing[g] = (st == SNOOZE);
    end

`ifdef ALARM_BEEP_EN
    logic beep_ph;

    // Phase restarts at 0 so the first ringing cycle is silent.
    always_ff @(posedge Pulse) begin
        if (Reset) begin
            beep_ph <= 1'b0;
        end else if ((|ringing) && (|ring_n)) begin
            beep_ph <= ~beep_ph;
        end else begin
            beep_ph <= 1'b0;
        end
    end

    assign buzz = (|ringing) & beep_ph;
`else
    logic buzz_q;

    always_ff @(posedge Pulse) begin
        if (Reset) begin
            buzz_q <= 1'b0;
        end else begin
            buzz_q <= |ring_n;
        end
    end

    assign buzz = buzz_q;
`endif

endmodule
